decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction-decode stage of the 16-bit CPU; sits directly downstream of fetch and consumes its
//  instruction/new_pc pair. Splits the instruction into fields and reads the 16x16 register file.
//  Sign-extends immediates and generates control. Registers the result into the ID/EX pipeline
//  register for execute. Detects load-use hazards (stall to fetch) and discards on branch flush.
// PARAMETERS
//  NUM_REGS   16  architectural registers; r0 reads 0 and ignores writes
//  DATA_W     16  register/data width
//  PC_W       16  program-counter width
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  reset         in   1      synchronous, active-high reset
//  if_valid      in   1      instruction/new_pc carry a real instruction
//  instruction   in   16     instruction word from fetch
//  new_pc        in   PC_W   PC of that instruction
//  flush         in   1      branch taken in memory stage (memory_stage_pc_sel); kill decode
//  wb_en         in   1      writeback write enable
//  wb_addr       in   4      writeback destination register
//  wb_data       in   DATA_W writeback data
//  stall         out  1      combinational; fetch holds instruction/new_pc while high
//  id_valid      out  1      ID/EX register holds a real instruction
//  id_opcode     out  4      opcode
//  id_rd         out  4      destination register
//  id_rs1/id_rs2 out  4      source indices (for execute-side forwarding)
//  id_rs1_data   out  DATA_W source-1 value
//  id_rs2_data   out  DATA_W source-2 value
//  id_imm        out  16     sign-extended immediate
//  id_pc         out  PC_W   PC of decoded instruction
//  id_reg_write, id_mem_read, id_mem_write, id_branch  out 1 each  control bits
// BEHAVIOUR
//  - Format: op=[15:12]. R: rd=[11:8] rs1=[7:4] rs2=[3:0] (ADD SUB AND OR XOR SHL SHR).
//    ADDI/LDI: rd=rs1=[11:8], imm=sext([7:0]). LD: rd=[11:8] rs1=[7:4] imm=sext([3:0]).
//    ST: rs2=[11:8] rs1=[7:4] imm=sext([3:0]). BEQZ: rs1=[11:8] imm=sext([7:0]).
//    JMP: imm=sext([11:0]). NOP=0x0, HALT=0xF; undefined opcodes decode as NOP.
//  - Reset: every id_* output 0, all registers 0; stall=0 during reset.
//  - Latency 1: fields sampled edge N appear on id_* after edge N.
//  - Load-use hazard: stall = if_valid & id_valid & id_mem_read & id_rd!=0 &
//    (id_rd==used rs1 | id_rd==used rs2). Only sources the opcode actually reads count.
//  - Stall cycle: ID/EX loads bubble (id_valid=0, all control 0); fetch re-presents the same word.
//  - Flush: at the edge where flush=1, ID/EX loads a bubble; flush beats stall. Stall is forced 0.
//  - if_valid=0: bubble loaded. Bubble contents: data fields 0.
//  - Writes: wb_en & wb_addr!=0 write at edge; writes to r0 dropped. r0 always reads 0.
//  - Reset asserted mid-stream: next edge clears everything regardless of stall/flush/wb_en.
// CONFIGURATION
//  WB_BYPASS_EN defined: same-cycle read of wb_addr (wb_en=1, addr!=0) returns wb_data.
//  Not defined: read returns old contents; execute must forward from writeback.
// STRUCTURE
//  cpu_pkg: opcode enum, field bit positions, ctrl_t struct (reg_write, mem_read, mem_write,
//  branch), sext helper functions. Shared with fetch and execute.
//  Sub-module decode_regfile: 2 async read ports, 1 sync write port, sync reset, bypass macro.
// TESTING
//  1 reset=1 two cycles -> all id_* 0, stall 0; read any reg -> 0.
//  2 wb r3<=0x1234, then ADD r5,r3,r3 (0x1533) -> id_rs1_data=id_rs2_data=0x1234, id_reg_write=1.
//  3 LD r2,[r1+0] then ADD r4,r2,r0 held by fetch -> stall=1 one cycle, bubble, then ADD issues.
//  4 flush=1 with ADDI r1,-1 (0x81FF) present -> id_valid=0 next cycle; if no flush, id_imm=0xFFFF.
//  5 wb r0<=0xBEEF -> r0 still reads 0. Same-edge wb r6<=0x00AA with read of r6:
//    0x00AA if WB_BYPASS_EN, else prior value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: opcode encoding, instruction
// field positions, the control-bit bundle and immediate sign-extension helpers.
// Used by fetch, decode and execute.
package cpu_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int PC_W     = 16;
  localparam int INSTR_W  = 16;
  localparam int REG_AW   = 4;
  localparam int IMM_W    = 16;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  // Encoding 0xE is unassigned and decodes as NOP.
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LDI  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_BEQZ = 4'hC,
    OP_JMP  = 4'hD,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  function automatic logic [IMM_W-1:0] sext4(input logic [3:0] v);
    return {{(IMM_W-4){v[3]}}, v};
  endfunction

  function automatic logic [IMM_W-1:0] sext8(input logic [7:0] v);
    return {{(IMM_W-8){v[7]}}, v};
  endfunction

  function automatic logic [IMM_W-1:0] sext12(input logic [11:0] v);
    return {{(IMM_W-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Decode-stage register file: two asynchronous read ports, one synchronous
// write port, synchronous active-high reset. r0 is hard-wired to zero.
// Build option WB_BYPASS_EN: a read of the register being written in the same
// cycle returns the incoming write data instead of the old contents.
module decode_regfile
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int DATA_W   = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_live;
  logic              bypass_a;
  logic              bypass_b;

  assign wr_live = wr_en && (wr_addr != 4'd0);

`ifdef WB_BYPASS_EN
  assign bypass_a = wr_live && (wr_addr == rd_addr_a);
  assign bypass_b = wr_live && (wr_addr == rd_addr_b);
`else
  assign bypass_a = 1'b0;
  assign bypass_b = 1'b0;
`endif

  // Storage update: reset clears every entry, otherwise write one non-zero register.
  // NOTE: the array is reset because architectural state must read 0 after reset;
  // a plain RAM that skips reset would leave X/garbage visible to software.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: r0 forced to zero, optional same-cycle writeback bypass.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != 4'd0) rd_data_a = bypass_a ? wr_data : regs[rd_addr_a];
    if (rd_addr_b != 4'd0) rd_data_b = bypass_b ? wr_data : regs[rd_addr_b];
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: splits the fetched word into fields, reads the
// register file, sign-extends immediates, builds control bits and registers the
// result into the ID/EX pipeline register. Detects load-use hazards (stall to
// fetch) and loads bubbles on flush / stall / no valid instruction.
// Build option WB_BYPASS_EN (passed to decode_regfile): same-cycle writeback bypass.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int PC_W     = cpu_pkg::PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [15:0]       instruction,
  input  logic [PC_W-1:0]   new_pc,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              id_valid,
  output logic [3:0]        id_opcode,
  output logic [3:0]        id_rd,
  output logic [3:0]        id_rs1,
  output logic [3:0]        id_rs2,
  output logic [DATA_W-1:0] id_rs1_data,
  output logic [DATA_W-1:0] id_rs2_data,
  output logic [15:0]       id_imm,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_branch
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [15:0]       imm;
    logic [PC_W-1:0]   pc;
    ctrl_t             ctrl;
  } idex_t;

  logic [3:0]        f_op;
  logic [3:0]        f_rd;
  logic [3:0]        f_rs1;
  logic [3:0]        f_rs2;

  opcode_e           dec_op;
  logic [3:0]        dec_rd;
  logic [3:0]        dec_rs1;
  logic [3:0]        dec_rs2;
  logic [15:0]       dec_imm;
  ctrl_t             dec_ctrl;

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  logic              load_use;
  logic              load_en;
  idex_t             idex;

  assign f_op  = instruction[OP_MSB:OP_LSB];
  assign f_rd  = instruction[RD_MSB:RD_LSB];
  assign f_rs1 = instruction[RS1_MSB:RS1_LSB];
  assign f_rs2 = instruction[RS2_MSB:RS2_LSB];

  // Field decode. Register indices an opcode does not use stay 0, so they read
  // r0 and can never match a non-zero load destination in the hazard check.
  always_comb begin
    dec_op   = OP_NOP;
    dec_rd   = 4'd0;
    dec_rs1  = 4'd0;
    dec_rs2  = 4'd0;
    dec_imm  = '0;
    dec_ctrl = '0;
    case (f_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        dec_op             = opcode_e'(f_op);
        dec_rd             = f_rd;
        dec_rs1            = f_rs1;
        dec_rs2            = f_rs2;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_ADDI, OP_LDI: begin
        dec_op             = opcode_e'(f_op);
        dec_rd             = f_rd;
        dec_rs1            = f_rd;
        dec_imm            = sext8(instruction[7:0]);
        dec_ctrl.reg_write = 1'b1;
      end
      OP_LD: begin
        dec_op             = OP_LD;
        dec_rd             = f_rd;
        dec_rs1            = f_rs1;
        dec_imm            = sext4(instruction[3:0]);
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.mem_read  = 1'b1;
      end
      OP_ST: begin
        dec_op             = OP_ST;
        dec_rs2            = f_rd;
        dec_rs1            = f_rs1;
        dec_imm            = sext4(instruction[3:0]);
        dec_ctrl.mem_write = 1'b1;
      end
      OP_BEQZ: begin
        dec_op             = OP_BEQZ;
        dec_rs1            = f_rd;
        dec_imm            = sext8(instruction[7:0]);
        dec_ctrl.branch    = 1'b1;
      end
      OP_JMP: begin
        dec_op             = OP_JMP;
        dec_imm            = sext12(instruction[11:0]);
        dec_ctrl.branch    = 1'b1;
      end
      OP_HALT: begin
        dec_op             = OP_HALT;
      end
      default: begin
        dec_op             = OP_NOP;
      end
    endcase
  end

  decode_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (dec_rs1),
    .rd_data_a (rs1_data),
    .rd_addr_b (dec_rs2),
    .rd_data_b (rs2_data),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // Load-use hazard: a load in ID/EX whose destination feeds a source of the
  // instruction now in decode. Flush and reset both suppress the stall.
  assign load_use = if_valid && idex.valid && idex.ctrl.mem_read &&
                    (idex.rd != 4'd0) &&
                    ((dec_rs1 == idex.rd) || (dec_rs2 == idex.rd));
  assign stall    = load_use && !flush && !reset;
  assign load_en  = if_valid && !flush && !load_use;

  // ID/EX pipeline register: reset clears, flush/stall/no-instruction load a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex <= '0;
    end else if (load_en) begin
      idex.valid    <= 1'b1;
      idex.opcode   <= dec_op;
      idex.rd       <= dec_rd;
      idex.rs1      <= dec_rs1;
      idex.rs2      <= dec_rs2;
      idex.rs1_data <= rs1_data;
      idex.rs2_data <= rs2_data;
      idex.imm      <= dec_imm;
      idex.pc       <= new_pc;
      idex.ctrl     <= dec_ctrl;
    end else begin
      idex <= '0;
    end
  end

  assign id_valid     = idex.valid;
  assign id_opcode    = idex.opcode;
  assign id_rd        = idex.rd;
  assign id_rs1       = idex.rs1;
  assign id_rs2       = idex.rs2;
  assign id_rs1_data  = idex.rs1_data;
  assign id_rs2_data  = idex.rs2_data;
  assign id_imm       = idex.imm;
  assign id_pc        = idex.pc;
  assign id_reg_write = idex.ctrl.reg_write;
  assign id_mem_read  = idex.ctrl.mem_read;
  assign id_mem_write = idex.ctrl.mem_write;
  assign id_branch    = idex.ctrl.branch;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a table of single-cycle decode vectors
// plus hand-written sequences for load-use stall, flush, r0, writeback bypass
// and mid-stream reset. Expected ID/EX contents go into a scoreboard queue when
// stimulus is driven and are compared after the following rising edge.
// Define WB_BYPASS_EN for both bench and RTL to exercise the bypass build.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [15:0] instruction;
  logic [15:0] new_pc;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [3:0]  id_rd;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic [15:0] id_rs1_data;
  logic [15:0] id_rs2_data;
  logic [15:0] id_imm;
  logic [15:0] id_pc;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;

  decode_stage dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .instruction  (instruction),
    .new_pc       (new_pc),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .stall        (stall),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rd        (id_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .id_imm       (id_imm),
    .id_pc        (id_pc),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_branch    (id_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [3:0]  ctrl;   // {reg_write, mem_read, mem_write, branch}
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    exp_t        exp;
  } vec_t;

  localparam exp_t BUBBLE = '0;

`ifdef WB_BYPASS_EN
  localparam logic [15:0] R6_SAME_EDGE = 16'h00AA;
`else
  localparam logic [15:0] R6_SAME_EDGE = 16'h0055;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[12];

  function automatic exp_t mk(input logic v, input logic [3:0] op, input logic [3:0] rd,
                              input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [15:0] d1, input logic [15:0] d2,
                              input logic [15:0] imm, input logic [15:0] pc,
                              input logic [3:0] ctrl);
    exp_t e;
    e.valid    = v;
    e.opcode   = op;
    e.rd       = rd;
    e.rs1      = rs1;
    e.rs2      = rs2;
    e.rs1_data = d1;
    e.rs2_data = d2;
    e.imm      = imm;
    e.pc       = pc;
    e.ctrl     = ctrl;
    return e;
  endfunction

  function automatic exp_t observed();
    return mk(id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
              id_imm, id_pc, {id_reg_write, id_mem_read, id_mem_write, id_branch});
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus: check the combinational stall, queue the expected
  // ID/EX contents, then compare after the edge.
  task automatic step(input string name, input logic rst, input logic v,
                      input logic [15:0] ins, input logic [15:0] pc, input logic fl,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic exp_stall, input exp_t exp);
    exp_t e;
    reset       = rst;
    if_valid    = v;
    instruction = ins;
    new_pc      = pc;
    flush       = fl;
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
    #1;
    check({name, " stall"}, 128'(stall), 128'(exp_stall));
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, 128'(observed()), 128'(e));
    end
  endtask

  task automatic idle_wb(input string name, input logic [3:0] wa, input logic [15:0] wd);
    step(name, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, wa, wd, 1'b0, BUBBLE);
  endtask

  task automatic issue(input string name, input logic [15:0] ins, input logic [15:0] pc,
                       input logic fl, input logic exp_stall, input exp_t exp);
    step(name, 1'b0, 1'b1, ins, pc, fl, 1'b0, 4'd0, 16'h0000, exp_stall, exp);
  endtask

  initial begin
    // Decode table: registers preloaded r1=0010 r3=1234 r6=0055 r7=F00F, others 0.
    vecs[0]  = '{16'h1533, mk(1, 4'h1, 4'd5,  4'd3, 4'd3, 16'h1234, 16'h1234, 16'h0000, 16'h0100, 4'b1000)};
    vecs[1]  = '{16'h2761, mk(1, 4'h2, 4'd7,  4'd6, 4'd1, 16'h0055, 16'h0010, 16'h0000, 16'h0102, 4'b1000)};
    vecs[2]  = '{16'h81FF, mk(1, 4'h8, 4'd1,  4'd1, 4'd0, 16'h0010, 16'h0000, 16'hFFFF, 16'h0104, 4'b1000)};
    vecs[3]  = '{16'h937F, mk(1, 4'h9, 4'd3,  4'd3, 4'd0, 16'h1234, 16'h0000, 16'h007F, 16'h0106, 4'b1000)};
    vecs[4]  = '{16'hA218, mk(1, 4'hA, 4'd2,  4'd1, 4'd0, 16'h0010, 16'h0000, 16'hFFF8, 16'h0108, 4'b1100)};
    vecs[5]  = '{16'hD800, mk(1, 4'hD, 4'd0,  4'd0, 4'd0, 16'h0000, 16'h0000, 16'hF800, 16'h010A, 4'b0001)};
    vecs[6]  = '{16'hB617, mk(1, 4'hB, 4'd0,  4'd1, 4'd6, 16'h0010, 16'h0055, 16'h0007, 16'h010C, 4'b0010)};
    vecs[7]  = '{16'hC7F0, mk(1, 4'hC, 4'd0,  4'd7, 4'd0, 16'hF00F, 16'h0000, 16'hFFF0, 16'h010E, 4'b0001)};
    vecs[8]  = '{16'h0000, mk(1, 4'h0, 4'd0,  4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0110, 4'b0000)};
    vecs[9]  = '{16'hE123, mk(1, 4'h0, 4'd0,  4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0112, 4'b0000)};
    vecs[10] = '{16'hF000, mk(1, 4'hF, 4'd0,  4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0114, 4'b0000)};
    vecs[11] = '{16'h4A97, mk(1, 4'h4, 4'd10, 4'd9, 4'd7, 16'h0000, 16'hF00F, 16'h0000, 16'h0116, 4'b1000)};

    // Reset for two cycles with live-looking inputs.
    step("reset0", 1'b1, 1'b1, 16'h1533, 16'h0040, 1'b0, 1'b1, 4'd3, 16'hDEAD, 1'b0, BUBBLE);
    step("reset1", 1'b1, 1'b1, 16'h1533, 16'h0042, 1'b0, 1'b1, 4'd3, 16'hDEAD, 1'b0, BUBBLE);
    issue("reset_regs_zero", 16'h1537, 16'h0044, 1'b0, 1'b0,
          mk(1, 4'h1, 4'd5, 4'd3, 4'd7, 16'h0000, 16'h0000, 16'h0000, 16'h0044, 4'b1000));

    // Preload registers through writeback while fetch is idle.
    idle_wb("wb_r1", 4'd1, 16'h0010);
    idle_wb("wb_r3", 4'd3, 16'h1234);
    idle_wb("wb_r6", 4'd6, 16'h0055);
    idle_wb("wb_r7", 4'd7, 16'hF00F);

    for (int i = 0; i < 12; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].ins, vecs[i].exp.pc, 1'b0, 1'b0, vecs[i].exp);
    end

    // Load-use on rs1: LD r2,[r1+0] then ADD r4,r2,r0 held for one stall cycle.
    issue("lu_ld", 16'hA210, 16'h0200, 1'b0, 1'b0,
          mk(1, 4'hA, 4'd2, 4'd1, 4'd0, 16'h0010, 16'h0000, 16'h0000, 16'h0200, 4'b1100));
    issue("lu_stall", 16'h1420, 16'h0202, 1'b0, 1'b1, BUBBLE);
    issue("lu_issue", 16'h1420, 16'h0202, 1'b0, 1'b0,
          mk(1, 4'h1, 4'd4, 4'd2, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0202, 4'b1000));

    // Load-use on the store-data source (rs2 = [11:8]).
    issue("lu2_ld", 16'hA210, 16'h0204, 1'b0, 1'b0,
          mk(1, 4'hA, 4'd2, 4'd1, 4'd0, 16'h0010, 16'h0000, 16'h0000, 16'h0204, 4'b1100));
    issue("lu2_stall", 16'hB210, 16'h0206, 1'b0, 1'b1, BUBBLE);
    issue("lu2_issue", 16'hB210, 16'h0206, 1'b0, 1'b0,
          mk(1, 4'hB, 4'd0, 4'd1, 4'd2, 16'h0010, 16'h0000, 16'h0000, 16'h0206, 4'b0010));

    // Load into r0 never stalls a reader of r0.
    issue("ld_r0", 16'hA010, 16'h0208, 1'b0, 1'b0,
          mk(1, 4'hA, 4'd0, 4'd1, 4'd0, 16'h0010, 16'h0000, 16'h0000, 16'h0208, 4'b1100));
    issue("ld_r0_use", 16'h1400, 16'h020A, 1'b0, 1'b0,
          mk(1, 4'h1, 4'd4, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h020A, 4'b1000));

    // Flush kills an ADDI; the same word without flush decodes normally.
    issue("flush_addi", 16'h81FF, 16'h0300, 1'b1, 1'b0, BUBBLE);
    issue("addi_noflush", 16'h81FF, 16'h0300, 1'b0, 1'b0,
          mk(1, 4'h8, 4'd1, 4'd1, 4'd0, 16'h0010, 16'h0000, 16'hFFFF, 16'h0300, 4'b1000));

    // Flush beats a pending load-use stall.
    issue("fb_ld", 16'hA210, 16'h0302, 1'b0, 1'b0,
          mk(1, 4'hA, 4'd2, 4'd1, 4'd0, 16'h0010, 16'h0000, 16'h0000, 16'h0302, 4'b1100));
    issue("fb_flush", 16'h1420, 16'h0304, 1'b1, 1'b0, BUBBLE);
    issue("fb_after", 16'h1420, 16'h0306, 1'b0, 1'b0,
          mk(1, 4'h1, 4'd4, 4'd2, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0306, 4'b1000));

    // No valid instruction behind a load: no stall, bubble.
    issue("iv_ld", 16'hA210, 16'h0308, 1'b0, 1'b0,
          mk(1, 4'hA, 4'd2, 4'd1, 4'd0, 16'h0010, 16'h0000, 16'h0000, 16'h0308, 4'b1100));
    step("iv_idle", 1'b0, 1'b0, 16'h1420, 16'h030A, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, BUBBLE);

    // Writes to r0 are dropped.
    idle_wb("wb_r0", 4'd0, 16'hBEEF);
    issue("r0_reads_zero", 16'h1400, 16'h0400, 1'b0, 1'b0,
          mk(1, 4'h1, 4'd4, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 4'b1000));

    // Same-edge writeback of r6 while decode reads r6.
    step("wb_same_edge", 1'b0, 1'b1, 16'h1466, 16'h0402, 1'b0, 1'b1, 4'd6, 16'h00AA, 1'b0,
         mk(1, 4'h1, 4'd4, 4'd6, 4'd6, R6_SAME_EDGE, R6_SAME_EDGE, 16'h0000, 16'h0402, 4'b1000));
    issue("wb_after", 16'h1466, 16'h0404, 1'b0, 1'b0,
          mk(1, 4'h1, 4'd4, 4'd6, 4'd6, 16'h00AA, 16'h00AA, 16'h0000, 16'h0404, 4'b1000));

    // Reset mid-stream with a load in ID/EX, a hazard word, flush and writeback all active.
    issue("mr_ld", 16'hA210, 16'h0500, 1'b0, 1'b0,
          mk(1, 4'hA, 4'd2, 4'd1, 4'd0, 16'h0010, 16'h0000, 16'h0000, 16'h0500, 4'b1100));
    step("mr_reset", 1'b1, 1'b1, 16'h1420, 16'h0502, 1'b1, 1'b1, 4'd5, 16'h7777, 1'b0, BUBBLE);
    issue("mr_regs_clear", 16'h1435, 16'h0504, 1'b0, 1'b0,
          mk(1, 4'h1, 4'd4, 4'd3, 4'd5, 16'h0000, 16'h0000, 16'h0000, 16'h0504, 4'b1000));

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
